// File: rtl/sum_accum.sv
// Block accumulator: sums BLOCK_LEN adder results into one total.
// Optional: SUM_ACCUM_SIGNED_EN selects signed extension/overflow.
module sum_accum #(
  parameter int DATA_W    = 32,
  parameter int ACC_W     = 40,
  parameter int BLOCK_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              flush,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_total,
  output logic [7:0]        out_count,
  output logic              out_ovf
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [7:0] BLK = 8'(BLOCK_LEN);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] tot_q, tot_d;
  logic [7:0]       ocnt_q, ocnt_d;
  logic             oovf_q, oovf_d;

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum_a;
  logic [7:0]       cnt_a;
  logic             ovf_a;
  logic             take;
  logic             close;

`ifdef SUM_ACCUM_SIGNED_EN
  assign ext   = {{(ACC_W-DATA_W){in_sum[DATA_W-1]}}, in_sum};
  assign sum_a = acc_q + ext;
  assign ovf_a = ovf_q
               | ((acc_q[ACC_W-1] == ext[ACC_W-1])
               &  (sum_a[ACC_W-1] != acc_q[ACC_W-1]));
`else
  logic cy;
  assign ext         = {{(ACC_W-DATA_W){1'b0}}, in_sum};
  assign {cy, sum_a} = {1'b0, acc_q} + {1'b0, ext};
  assign ovf_a       = ovf_q | cy;
`endif

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_total = tot_q;
  assign out_count = ocnt_q;
  assign out_ovf   = oovf_q;

  assign take  = in_valid & in_ready;
  assign cnt_a = cnt_q + 8'd1;
  assign close = (take && (cnt_a == BLK))
              || (in_ready && flush && ((cnt_q != 8'd0) || take));

  // Next-state: clear wins, then result drain, then accumulation.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    tot_d   = tot_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == HOLD) begin
      if (out_ready) begin
        state_d = ACCUM;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    end else begin
      if (take) begin
        acc_d = sum_a;
        cnt_d = cnt_a;
        ovf_d = ovf_a;
      end
      if (close) begin
        state_d = HOLD;
        tot_d   = take ? sum_a : acc_q;
        ocnt_d  = take ? cnt_a : cnt_q;
        oovf_d  = take ? ovf_a : ovf_q;
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      tot_q   <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      tot_q   <= tot_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
  end

endmodule
